alu_muldiv_controller: RTL and testbench
========================================

Name: alu_muldiv_controller

Overview:
- Multi-cycle successor to the single-cycle ALU operation decoder. It decodes RV32M instructions (R-type ALUOp with Funct7=0000001) and runs them on an internal iterative shift-add multiplier and restoring divider.
- Parametrised in data width.
- Sits beside the ALU in the execute stage and drives the pipeline stall through a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; ≥4, power of two.
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ALUOp  in  3  controller op class; 3'b010 = R-type.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12; selects the M op.
- SrcA  in  XLEN  rs1 value.
- SrcB  in  XLEN  rs2 value.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  unit can accept.
- flush  in  1  abort any operation in flight.
- md_sel  out  1  combinational: in_valid && ALUOp==3'b010 && Funct7==7'b0000001.
- busy  out  1  state != IDLE; the pipeline stalls on md_sel || busy.
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer takes Result.
- Result  out  XLEN  M-op result.

Behaviour:
- Reset values: state=IDLE, out_valid=0, Result=0, busy=0, counter=0. in_ready=1 in the cycle after reset.
- Reset or flush in any state goes to IDLE at the next edge and discards the operation; no out_valid is produced.
- If reset and flush are both high, reset wins; the outcome is identical.
- Funct3 decode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_ready = (state==IDLE).
- Accept: edge where in_valid && md_sel && in_ready.
  - Latch |SrcA| and |SrcB| per op signedness, plus the sign flags.
  - Signedness: MULH is signed×signed; MULHSU is signed×unsigned; DIV and REM are signed; the rest are unsigned.
  - counter = XLEN-1.
- Requests with md_sel=0 are ignored (in_ready is still high).
- States:
  - IDLE: accept → MUL (ops 0-3) or DIV (ops 4-7). Special divide cases go → DONE directly.
  - MUL: one shift-add iteration per cycle on a 2·XLEN accumulator. At counter==0 → DONE. Otherwise counter−1.
  - DIV: one restoring subtract/shift per cycle, producing XLEN quotient bits. At counter==0 → DONE.
  - DONE: out_valid=1. Result stays stable until out_valid && out_ready, then → IDLE the next edge.
- Back-to-back ops: the next accept is possible on the edge after the handshake edge (one IDLE cycle).
- Latency: acceptance at edge T gives out_valid at edge T+XLEN+1 for normal ops, and at edge T+1 for special cases.
- Sign fix-up in the final iteration, applied before DONE:
  - Product negated when signs differ.
  - Quotient negated when sa^sb.
  - Remainder takes the sign of the dividend.
- MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN].
- Divide by zero (SrcB==0): DIV/DIVU return all ones. REM/REMU return SrcA.
- Signed overflow (SrcA==1<<(XLEN-1), SrcB==all ones, DIV/REM): DIV returns SrcA, REM returns 0.
- Operand changes after acceptance have no effect.
- out_ready held low keeps DONE indefinitely; no overwrite.

Test Plan:
- MUL 7×(-3): SrcA=32'd7, SrcB=32'hFFFFFFFD, Funct3=000, accept at T → out_valid at T+33, Result=32'hFFFFFFEB.
- MULH / MULHU of 32'h80000000 × 32'h80000000:
  - MULH → 32'h40000000.
  - MULHU → 32'h40000000.
  - MULHSU(32'hFFFFFFFF, 32'hFFFFFFFF) → 32'hFFFFFFFF.
- DIV/REM -7/2:
  - DIV → 32'hFFFFFFFD.
  - REM → 32'hFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Each with latency XLEN+1.
- Special cases, all with out_valid at T+1:
  - DIV x/0 → 32'hFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 32'h80000000 / 32'hFFFFFFFF → 32'h80000000.
  - REM of the same operands → 0.
- Handshake: out_ready=0 for 10 cycles after out_valid → Result stable, busy=1, in_ready=0. Then out_ready=1 → in_ready=1 at the next edge.
- Abort: flush at cycle 10 of a DIV → next cycle IDLE, in_ready=1, no out_valid. Repeating with reset mid-MUL gives all outputs at their reset values.

Source files
------------

// File: rtl/alu_muldiv_controller.sv
// alu_muldiv_controller
// ---------------------
// Multi-cycle RV32M execution unit that sits beside the ALU in the execute
// stage. It decodes the M-extension (R-type, Funct7=0000001) and runs
// multiplies on an iterative shift-add engine and divides on a restoring
// divider. Both engines share one 2*XLEN accumulator.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   ALUOp, Funct7, Funct3 instruction decode fields
//   SrcA, SrcB            rs1 / rs2 operand values
//   in_valid / in_ready   request handshake (ready only while idle)
//   flush                 abort any operation in flight
//   md_sel                combinational "this is an M-op" decode
//   busy                  unit is not idle; pipeline stalls on md_sel||busy
//   out_valid / out_ready result handshake
//   Result                M-op result, held stable until taken
module alu_muldiv_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            md_sel,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend being shifted into quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiply: |multiplicand|. Divide: |divisor|.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  // ---------------------------------------------------------------- decode
  logic            accept;
  logic            signed_a, signed_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            is_div;
  logic            div_by_zero, div_overflow, special;
  logic [XLEN-1:0] special_result;

  assign md_sel    = in_valid && (ALUOp == 3'b010) && (Funct7 == 7'b0000001);
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign accept    = md_sel && in_ready;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 so.
  assign signed_a = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign signed_b = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                    (Funct3 == 3'b110);
  assign neg_a    = signed_a && SrcA[XLEN-1];
  assign neg_b    = signed_b && SrcB[XLEN-1];
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude.
  assign abs_a    = neg_a ? -SrcA : SrcA;
  assign abs_b    = neg_b ? -SrcB : SrcB;

  assign is_div       = Funct3[2];
  assign div_by_zero  = (SrcB == '0);
  assign div_overflow = !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
  assign special      = is_div && (div_by_zero || div_overflow);

  // Funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    special_result = SrcA;
    if (div_by_zero) begin
      special_result = Funct3[1] ? SrcA : '1;
    end else begin
      special_result = Funct3[1] ? '0 : SrcA;
    end
  end

  // ----------------------------------------------------- iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_result;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign prod_fix = (sa_q ^ sb_q) ? -mul_next : mul_next;
  assign mul_result = (op_q == 3'b000) ? prod_fix[XLEN-1:0]
                                       : prod_fix[2*XLEN-1:XLEN];

  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_fin, rem_fin;
  logic [XLEN-1:0]   div_result;

  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  // When div_ge holds the true difference is below the divisor, so the
  // low XLEN bits of the modular subtraction are exact.
  assign div_sub   = div_shift[XLEN-1:0] - opnd_q;
  assign div_rem   = div_ge ? div_sub : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
  assign quo_fin   = (sa_q ^ sb_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_fin   = sa_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  assign div_result = op_q[1] ? rem_fin : quo_fin;

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    op_d        = op_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d  = Funct3;
            sa_d  = neg_a;
            sb_d  = neg_b;
            cnt_d = CNT_W'(XLEN - 1);
            if (special) begin
              result_d = special_result;
              state_d  = S_DONE;
            end else if (is_div) begin
              acc_d   = {{XLEN{1'b0}}, abs_a};
              opnd_d  = abs_b;
              state_d = S_DIV;
            end else begin
              acc_d   = {{XLEN{1'b0}}, abs_b};
              opnd_d  = abs_a;
              state_d = S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          if (cnt_q == '0) begin
            result_d = mul_result;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          if (cnt_q == '0) begin
            result_d = div_result;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          // Result is already final on entry; out_valid rises one edge
          // later and then holds until the consumer takes it.
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      op_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      op_q        <= op_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Self-checking bench for alu_muldiv_controller (XLEN=32).
// A cycle-level reference model predicts in_ready/busy/out_valid/md_sel and
// Result from the arithmetic definition of each M-op and its latency rule;
// a single negedge process compares the DUT against it every cycle.
module tb_alu_muldiv_controller;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      ALUOp = 3'b000;
  logic [6:0]      Funct7 = 7'b0;
  logic [2:0]      Funct3 = 3'b000;
  logic [XLEN-1:0] SrcA = '0;
  logic [XLEN-1:0] SrcB = '0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            md_sel;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] Result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv_controller #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .md_sel(md_sel), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic definition of every M-op.
  function automatic logic [31:0] ref_md(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint    sa;
    longint    sb;
    longint    ua;
    longint    ub;
    logic [63:0] p;
    int        ia;
    int        ib;
    int        q;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = ia / ib; return q;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = ia % ib; return q;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  // ------------------------------------------------------ reference model
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_res_zero = 1'b1;
  int          m_valid_edge = 0;
  logic [31:0] m_result = '0;
  bit          exp_ov;
  bit          exp_md;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_md = in_valid && ALUOp == 3'b010 && Funct7 == 7'b0000001;
    exp_ov = m_busy && (cyc >= m_valid_edge);
    if (cyc > 0) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      check("md_sel", {31'b0, md_sel}, {31'b0, exp_md});
      if (exp_ov) check("Result", Result, m_result);
      else if (m_res_zero) check("Result_reset", Result, 32'h0);
    end
    if (reset) begin
      m_busy = 1'b0;
      m_res_zero = 1'b1;
    end else if (flush) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (exp_md) begin
        m_busy = 1'b1;
        m_res_zero = 1'b0;
        m_result = ref_md(Funct3, SrcA, SrcB);
        m_valid_edge = cyc + 1 + (is_special(Funct3, SrcA, SrcB) ? 1 : XLEN + 1);
      end
    end else if (exp_ov && out_ready) begin
      m_busy = 1'b0;
    end
  end

  // ----------------------------------------------------------- driver side
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("wait_in_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; ALUOp = 3'b010; Funct7 = 7'b0000001;
    Funct3 = f3; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    // Scramble operands after acceptance; Funct7 keeps md_sel low.
    in_valid = 1'($urandom); ALUOp = 3'($urandom); Funct7 = 7'b0100000;
    Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic finish_op(input bit chk, input logic [31:0] lit,
                           input int lit_lat, input int hold,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk); #1; n++;
      if (out_valid) got = 1'b1;
    end
    if (!got) check("out_valid_timeout", 32'h0, 32'h1);
    if (chk) begin
      check("lit_result", Result, lit);
      check("lit_latency", n, lit_lat);
    end
    $display("[TB] op f3=%0d a=%h b=%h result=%h lat=%0d", f3, a, b, Result, n);
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      check("hold_busy", {31'b0, busy}, 32'h1);
      check("hold_in_ready", {31'b0, in_ready}, 32'h0);
      check("hold_valid", {31'b0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", {31'b0, in_ready}, 32'h1);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit,
                       input int lat, input int hold);
    start_op(f3, a, b);
    finish_op(1'b1, lit, lat, hold, f3, a, b);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_Result", Result, 32'h0);

    // Pin the reference model to hand-computed values.
    check("model_mul", ref_md(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("model_mulh", ref_md(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("model_mulhsu", ref_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    check("model_div", ref_md(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("model_rem", ref_md(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("model_divu", ref_md(3'd5, 32'd100, 32'd7), 32'd14);

    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    do_op(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op(3'd4, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 0);
    do_op(3'd7, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);

    // Non-M requests are ignored.
    in_valid = 1'b1; ALUOp = 3'b000; Funct7 = 7'b0000001;
    repeat (3) @(posedge clk);
    #1 check("ignored_busy", {31'b0, busy}, 32'h0);
    in_valid = 1'b0;

    // Consumer stall: result held for 10 cycles.
    do_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 33, 10);

    // Flush at cycle 10 of a divide.
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_valid", {31'b0, out_valid}, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    start_op(3'd0, 32'd99, 32'd77);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mrst_in_ready", {31'b0, in_ready}, 32'h1);
    check("mrst_busy", {31'b0, busy}, 32'h0);
    check("mrst_valid", {31'b0, out_valid}, 32'h0);
    check("mrst_Result", Result, 32'h0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations, checked by the model process.
    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      start_op(rf, ra, rb);
      finish_op(1'b0, 32'h0, 0, $urandom_range(0, 3), rf, ra, rb);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
